// File: rtl/rlgl_game_ctrl.sv
// rlgl_game_ctrl
//   Frame-synchronous Red-Light-Green-Light game sequencer. Decodes PS/2 make
//   and break codes, steps through COUNTDOWN / GREEN / RED phases on frame
//   ticks, advances the player sprite and decides the CAUGHT and WIN outcomes.
//   pixel_gen only draws what this block reports.
//
// Ports
//   clk          in   1   system clock, posedge
//   rst          in   1   asynchronous reset, active-high
//   frame_tick   in   1   one-cycle pulse per video frame
//   key_valid    in   1   one-cycle pulse, key_code carries a new PS/2 byte
//   key_code     in   8   PS/2 scan-code byte
//   state        out  3   0 IDLE, 1 COUNTDOWN, 2 GREEN, 3 RED, 4 CAUGHT, 5 WIN
//   light_green  out  1   high while in GREEN
//   player_x     out  10  player sprite x position
//   frames_left  out  8   frames remaining in the current timed phase
//   game_over    out  1   high while in CAUGHT
//   win          out  1   high while in WIN
module rlgl_game_ctrl #(
    parameter int         COUNT_FRAMES = 120,
    parameter int         GREEN_FRAMES = 180,
    parameter int         RED_FRAMES   = 120,
    parameter int         GRACE_FRAMES = 15,
    parameter logic [9:0] START_X      = 10'd16,
    parameter logic [9:0] FINISH_X     = 10'd600,
    parameter logic [9:0] STEP         = 10'd4,
    parameter logic [7:0] KEY_START    = 8'h29,
    parameter logic [7:0] KEY_MOVE     = 8'h1D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic [2:0] state,
    output logic       light_green,
    output logic [9:0] player_x,
    output logic [7:0] frames_left,
    output logic       game_over,
    output logic       win
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_GREEN     = 3'd2,
        S_RED       = 3'd3,
        S_CAUGHT    = 3'd4,
        S_WIN       = 3'd5
    } state_t;

    localparam logic [7:0] L_BREAK      = 8'hF0;
    localparam logic [7:0] L_COUNT_LAST = 8'(COUNT_FRAMES - 1);
    localparam logic [7:0] L_GREEN_LAST = 8'(GREEN_FRAMES - 1);
    localparam logic [7:0] L_RED_LAST   = 8'(RED_FRAMES - 1);
    localparam logic [7:0] L_GRACE      = 8'(GRACE_FRAMES);

    state_t      r_state;
    logic [7:0]  r_frames;
    logic [9:0]  r_x;
    logic        r_break;
    logic        r_pend;
    logic        r_light_green;
    logic        r_game_over;
    logic        r_win;

    state_t      w_state_nx;
    logic [7:0]  w_frames_nx;
    logic [9:0]  w_x_nx;
    logic        w_break_nx;
    logic        w_pend_nx;

    state_t      w_tmr_state;
    logic [7:0]  w_tmr_frames;

    logic        w_make;
    logic        w_make_start;
    logic        w_make_move;
    logic        w_taken;
    logic        w_in_grace;
    logic [10:0] w_sum;
    logic [9:0]  w_step_x;

    // A byte is a make code only when it is not F0 and does not follow an F0.
    assign w_make       = key_valid && !r_break && (key_code != L_BREAK);
    assign w_make_start = w_make && (key_code == KEY_START);
    assign w_make_move  = w_make && (key_code == KEY_MOVE);
    assign w_taken      = r_pend || w_make_move;

    // In RED, frames_left counts down from L_RED_LAST, so the difference is
    // the number of RED frames already elapsed.
    assign w_in_grace   = (L_RED_LAST - r_frames) < L_GRACE;

    // 11-bit sum so that a step near the top of the range cannot wrap.
    assign w_sum        = {1'b0, r_x} + {1'b0, STEP};
    assign w_step_x     = (w_sum > {1'b0, FINISH_X}) ? FINISH_X : w_sum[9:0];

    // Result of a plain timer tick in the current timed phase.
    always_comb begin
        w_tmr_state  = r_state;
        w_tmr_frames = r_frames;
        if (r_frames != 8'd0) begin
            w_tmr_frames = r_frames - 8'd1;
        end else begin
            case (r_state)
                S_COUNTDOWN: begin w_tmr_state = S_GREEN; w_tmr_frames = L_GREEN_LAST; end
                S_GREEN:     begin w_tmr_state = S_RED;   w_tmr_frames = L_RED_LAST;   end
                S_RED:       begin w_tmr_state = S_GREEN; w_tmr_frames = L_GREEN_LAST; end
                default:     begin w_tmr_state = r_state; w_tmr_frames = r_frames;     end
            endcase
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_frames_nx = r_frames;
        w_x_nx      = r_x;
        w_pend_nx   = r_pend;
        w_break_nx  = r_break;

        if (key_valid) begin
            w_break_nx = (key_code == L_BREAK);
        end

        case (r_state)
            S_IDLE, S_CAUGHT, S_WIN: begin
                if (w_make_start) begin
                    w_state_nx  = S_COUNTDOWN;
                    w_frames_nx = L_COUNT_LAST;
                    w_x_nx      = START_X;
                    w_pend_nx   = 1'b0;
                end
            end
            S_COUNTDOWN: begin
                if (frame_tick) begin
                    w_state_nx  = w_tmr_state;
                    w_frames_nx = w_tmr_frames;
                end
            end
            S_GREEN, S_RED: begin
                if (frame_tick) begin
                    w_pend_nx = 1'b0;
                    if (w_taken && (r_state == S_GREEN || w_in_grace)) begin
                        w_x_nx = w_step_x;
                        // Reaching the finish line beats the phase timer.
                        if (w_step_x == FINISH_X) begin
                            w_state_nx  = S_WIN;
                            w_frames_nx = 8'd0;
                        end else begin
                            w_state_nx  = w_tmr_state;
                            w_frames_nx = w_tmr_frames;
                        end
                    end else if (w_taken) begin
                        // Moving on red after the grace window beats the timer.
                        w_state_nx  = S_CAUGHT;
                        w_frames_nx = 8'd0;
                    end else begin
                        w_state_nx  = w_tmr_state;
                        w_frames_nx = w_tmr_frames;
                    end
                end else if (w_make_move) begin
                    w_pend_nx = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_frames      <= 8'd0;
            r_x           <= START_X;
            r_break       <= 1'b0;
            r_pend        <= 1'b0;
            r_light_green <= 1'b0;
            r_game_over   <= 1'b0;
            r_win         <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_frames      <= w_frames_nx;
            r_x           <= w_x_nx;
            r_break       <= w_break_nx;
            r_pend        <= w_pend_nx;
            r_light_green <= (w_state_nx == S_GREEN);
            r_game_over   <= (w_state_nx == S_CAUGHT);
            r_win         <= (w_state_nx == S_WIN);
        end
    end

    assign state       = r_state;
    assign light_green = r_light_green;
    assign player_x    = r_x;
    assign frames_left = r_frames;
    assign game_over   = r_game_over;
    assign win         = r_win;

endmodule

// File: tb/tb_rlgl_game_ctrl.sv
module tb_rlgl_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic [2:0] state;
    logic       light_green;
    logic [9:0] player_x;
    logic [7:0] frames_left;
    logic       game_over;
    logic       win;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: game situation as plain integers.
    int m_st, m_fl, m_x;
    bit m_brk, m_pend;

    always #5 clk = ~clk;

    rlgl_game_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .key_valid(key_valid), .key_code(key_code),
        .state(state), .light_green(light_green), .player_x(player_x),
        .frames_left(frames_left), .game_over(game_over), .win(win)
    );

    task automatic model_reset();
        m_st = 0; m_fl = 0; m_x = 16; m_brk = 0; m_pend = 0;
    endtask

    task automatic model_timer();
        if (m_fl != 0) m_fl = m_fl - 1;
        else if (m_st == 1) begin m_st = 2; m_fl = 179; end
        else if (m_st == 2) begin m_st = 3; m_fl = 119; end
        else if (m_st == 3) begin m_st = 2; m_fl = 179; end
    endtask

    task automatic model_step(input bit tk, input bit kv, input logic [7:0] kc);
        bit mk_s, mk_m, taken;
        int nx;
        mk_s = kv && !m_brk && kc == 8'h29;
        mk_m = kv && !m_brk && kc == 8'h1D;
        if (kv) m_brk = (kc == 8'hF0);
        if (m_st == 0 || m_st == 4 || m_st == 5) begin
            if (mk_s) begin m_st = 1; m_fl = 119; m_x = 16; m_pend = 0; end
        end else if (m_st == 1) begin
            if (tk) model_timer();
        end else begin
            if (tk) begin
                taken = m_pend || mk_m;
                m_pend = 0;
                if (taken && (m_st == 2 || (119 - m_fl) < 15)) begin
                    nx = m_x + 4;
                    if (nx > 600) nx = 600;
                    m_x = nx;
                    if (nx == 600) begin m_st = 5; m_fl = 0; end
                    else model_timer();
                end else if (taken) begin
                    m_st = 4; m_fl = 0;
                end else begin
                    model_timer();
                end
            end else if (mk_m) begin
                m_pend = 1;
            end
        end
    endtask

    task automatic check_model();
        logic [2:0] e_st;
        logic [9:0] e_x;
        logic [7:0] e_fl;
        logic       e_lg, e_go, e_w;
        e_st = 3'(m_st); e_x = 10'(m_x); e_fl = 8'(m_fl);
        e_lg = (m_st == 2); e_go = (m_st == 4); e_w = (m_st == 5);
        n_vec++;
        if (state !== e_st || player_x !== e_x || frames_left !== e_fl ||
            light_green !== e_lg || game_over !== e_go || win !== e_w) begin
            n_err++;
            $display("FAIL model t=%0t got st=%0d x=%0d fl=%0d lg=%b go=%b w=%b want st=%0d x=%0d fl=%0d lg=%b go=%b w=%b",
                     $time, state, player_x, frames_left, light_green, game_over, win,
                     e_st, e_x, e_fl, e_lg, e_go, e_w);
        end
    endtask

    task automatic chk_lit(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, clock edge, update model, sample #1 later.
    task automatic cyc(input bit tk, input bit kv, input logic [7:0] kc);
        frame_tick = tk; key_valid = kv; key_code = kc;
        @(posedge clk);
        model_step(tk, kv, kc);
        #1;
        check_model();
        frame_tick = 1'b0; key_valid = 1'b0; key_code = 8'h00;
    endtask

    task automatic tick_until_state(input int want, input int budget);
        int n;
        n = 0;
        while (m_st != want && n < budget) begin
            cyc(1, 0, 8'h00);
            cyc(0, 0, 8'h00);
            n++;
        end
        if (m_st != want) begin
            n_vec++; n_err++;
            $display("FAIL wait_state budget expired want %0d got %0d", want, m_st);
        end
    endtask

    initial begin
        logic [7:0] codes [4];
        int guard;
        codes[0] = 8'h29; codes[1] = 8'h1D; codes[2] = 8'hF0; codes[3] = 8'h1C;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_model();
        chk_lit("reset_state", state, 0);
        chk_lit("reset_x", player_x, 16);
        chk_lit("reset_fl", frames_left, 0);
        rst = 1'b0;

        // Start the game.
        cyc(0, 1, 8'h29);
        chk_lit("start_state", state, 1);
        chk_lit("start_fl", frames_left, 119);
        chk_lit("start_x", player_x, 16);
        repeat (120) cyc(1, 0, 8'h00);
        chk_lit("green_state", state, 2);
        chk_lit("green_light", light_green, 1);

        // Pending move, then a released key that must be ignored.
        cyc(0, 1, 8'h1D);
        cyc(1, 0, 8'h00);
        chk_lit("move_x", player_x, 20);
        cyc(0, 1, 8'hF0);
        cyc(0, 1, 8'h1D);
        cyc(1, 0, 8'h00);
        chk_lit("release_x", player_x, 20);

        // Grace window and CAUGHT.
        tick_until_state(3, 400);
        repeat (5) cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h1D);
        cyc(1, 0, 8'h00);
        chk_lit("grace_x", player_x, 24);
        chk_lit("grace_state", state, 3);
        guard = 0;
        while (m_fl > 99 && guard < 200) begin cyc(1, 0, 8'h00); guard++; end
        cyc(0, 1, 8'h1D);
        cyc(1, 0, 8'h00);
        chk_lit("caught_state", state, 4);
        chk_lit("caught_go", game_over, 1);
        chk_lit("caught_x", player_x, 24);
        repeat (3) cyc(1, 0, 8'h00);
        chk_lit("caught_sticky", state, 4);

        // Restart from CAUGHT.
        cyc(0, 1, 8'h29);
        chk_lit("restart_state", state, 1);
        chk_lit("restart_x", player_x, 16);
        chk_lit("restart_go", game_over, 0);
        tick_until_state(2, 400);

        // Move key in the same cycle as the frame tick.
        cyc(1, 1, 8'h1D);
        chk_lit("sametick_x", player_x, 20);

        // Arrange the final move to land on the last GREEN frame.
        guard = 0;
        while (m_fl > 144 && guard < 200) begin cyc(1, 0, 8'h00); guard++; end
        guard = 0;
        while (m_st == 2 && guard < 200) begin cyc(1, 1, 8'h1D); guard++; end
        chk_lit("win_x", player_x, 600);
        chk_lit("win_state", state, 5);
        chk_lit("win_flag", win, 1);
        chk_lit("win_fl", frames_left, 0);
        chk_lit("win_light", light_green, 0);

        // Asynchronous reset in the middle of RED.
        cyc(0, 1, 8'h29);
        tick_until_state(3, 600);
        repeat (7) cyc(1, 0, 8'h00);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_lit("async_state", state, 0);
        chk_lit("async_x", player_x, 16);
        chk_lit("async_fl", frames_left, 0);
        check_model();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        cyc(0, 1, 8'h1D);
        cyc(1, 0, 8'h00);
        cyc(1, 1, 8'h1D);
        chk_lit("post_rst_state", state, 0);
        chk_lit("post_rst_x", player_x, 16);

        // Randomized play.
        for (int i = 0; i < 6000; i++) begin
            bit tk, kv;
            logic [7:0] kc;
            tk = ($urandom_range(0, 2) == 0);
            kv = ($urandom_range(0, 3) == 0);
            kc = codes[$urandom_range(0, 3)];
            // Keep restarts rare so games get far enough to win or be caught.
            if (kc == 8'h29 && $urandom_range(0, 19) != 0) kc = 8'h1D;
            cyc(tk, kv, kc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
